// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the signed-overflow rule for a - b.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 4;

   // a - b overflows only when the operand signs differ and the result sign
   // disagrees with the minuend.
   function automatic logic calc_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out bout.
module full_sub_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first, with valid/ready handshakes on operand and result sides.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int                IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               bin_q, bin_d;
   logic               borrow_q, borrow_d;
   logic               overflow_q, overflow_d;

   logic               cell_d;
   logic               cell_bout;

   full_sub_cell u_cell (
      .x    (a_q[idx_q]),
      .y    (b_q[idx_q]),
      .bin  (bin_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the
      // case leaves one unassigned, which would infer a latch.
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      diff_d     = diff_q;
      idx_d      = idx_q;
      bin_d      = bin_q;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               diff_d  = '0;
               bin_d   = 1'b0;
               idx_d   = '0;
               state_d = CALC;
            end
         end

         CALC: begin
            diff_d[idx_q] = cell_d;
            bin_d         = cell_bout;
            // The last bit goes straight to DONE so the index never wraps.
            if (idx_q == LAST_IDX) begin
               borrow_d   = cell_bout;
               overflow_d = calc_overflow(a_q[WIDTH-1], b_q[WIDTH-1], cell_d);
               state_d    = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         diff_q     <= '0;
         idx_q      <= '0;
         bin_q      <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         diff_q     <= diff_d;
         idx_q      <= idx_d;
         bin_q      <= bin_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign overflow  = overflow_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor that computes `diff = a - b` one bit per clock, LSB first. A single one-bit full-subtractor cell is iterated across the operand width. It is the inverse-direction companion to the team's ripple-carry adder. It trades area for latency and sits behind a valid/ready handshake on both sides, so it can be dropped between operand producers and result consumers in the datapath. It reports the unsigned borrow-out and the signed overflow flag.

## Interface
- `WIDTH`, 4, operand and result width in bits; legal range WIDTH ≥ 2.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  operands `a`, `b` valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  minuend, two's complement.
- `b`  input  WIDTH  subtrahend, two's complement.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer takes result.
- `diff`  output  WIDTH  `a - b`, modulo 2^WIDTH.
- `borrow`  output  1  1 when unsigned `a < b`.
- `overflow`  output  1  signed result not representable.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `a` and `b`, clear `diff` to 0, clear the running borrow, clear the bit index, and go to CALC.
- CALC:
  - Each cycle, feed `a[i]`, `b[i]` and the running borrow into the cell.
  - Write the cell's difference output to `diff[i]` and register its borrow-out.
  - Increment `i`.
  - After bit WIDTH-1, register `borrow` (the final borrow-out) and `overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB])`, then go to DONE.
- DONE:
  - `out_valid` = 1; `diff`, `borrow` and `overflow` are held stable.
  - On `out_ready`, go to IDLE.
- Cell equations: `d = x ^ y ^ bin`; `bout = (~x & y) | (~x & bin) | (y & bin)`.
- `in_ready` is 0 in CALC and DONE. `in_valid` and `a`/`b` are ignored there; operands are sampled only at acceptance.
- `in_ready` and `out_valid` are decoded from the FSM state. All other outputs are registered.
- Bit index counter width is `$clog2(WIDTH)`. The index never wraps past WIDTH-1; the transition to DONE takes priority.
- Reset, whether asserted mid-CALC or mid-DONE, aborts the operation immediately: FSM goes to IDLE and the partial result is discarded. No `out_valid` pulse is produced for the aborted operation.

## Timing
- Reset values:
  - FSM = IDLE, so `in_ready` = 1.
  - `out_valid`, `diff`, `borrow`, `overflow` = 0.
- Latency: operands accepted on edge N; `out_valid` rises after edge N+WIDTH.
- Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH CALC cycles, DONE handshake, IDLE).
- Output handshake: the result transfers on the first edge with `out_valid & out_ready`; `in_ready` is 1 from the following cycle.
- `out_ready` held high before DONE gives a single-cycle DONE.
- While `out_valid & ~out_ready`, every output is held bit-stable.
- In CALC, `diff` bits update one per cycle LSB-first. `diff` is only architecturally meaningful while `out_valid` = 1.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE/CALC/DONE),
  - the default-width constant (4),
  - the overflow-flag function if reused elsewhere.
- One sub-module, `full_sub_cell`: purely combinational one-bit full subtractor with ports `x`, `y`, `bin`, `d`, `bout`. The top level contains the FSM, operand/result shift registers and the index counter.

## Test plan
- WIDTH=4, a=7, b=3 → diff=4'b0100, borrow=0, overflow=0; `out_valid` exactly 4 cycles after acceptance.
- a=3, b=5 → diff=4'b1110, borrow=1, overflow=0.
- a=4'b0111, b=4'b1000 → diff=4'b1111, borrow=1, overflow=1.
- a=4'b1000, b=4'b0001 → diff=4'b0111, borrow=0, overflow=1.
- Backpressure: `out_ready` low for 5 cycles in DONE, with `in_valid` pulsed and new operands applied meanwhile →
  - outputs stay stable and `in_ready` stays 0;
  - after `out_ready` rises, the next cycle is IDLE and the new operands are accepted only then.
- Reset asserted at the 3rd CALC cycle →
  - all outputs return to reset values asynchronously;
  - `in_ready` = 1 after release and no `out_valid` occurs;
  - an exhaustive 256-pair sweep afterwards matches the reference model.
